// File: rtl/psum_accum_ctrl.sv
// PL-side psum BRAM sequencer: read-modify-write accumulation of partial sums and range zero-fill.
// Latency: accumulate occupies READ_LATENCY+3 cycles accept-to-ready, first-pass write 2 cycles, clear len+1 cycles.
// Backpressure: o_psum_ready drops while an op is in flight, a clear is requested, or the PS owns the BRAM.
module psum_accum_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_BYTE     = 4,
    parameter int READ_LATENCY = 2,
    parameter int SATURATE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           i_conf_ctrl,
    input  logic                  i_psum_valid,
    output logic                  o_psum_ready,
    input  logic [ADDR_WIDTH-1:0] i_psum_addr,
    input  logic [DATA_WIDTH-1:0] i_psum_data,
    input  logic                  i_psum_first,
    input  logic                  i_clr_start,
    input  logic [ADDR_WIDTH-1:0] i_clr_base,
    input  logic [ADDR_WIDTH-1:0] i_clr_len,
    output logic                  o_clr_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idat,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    output logic [NUM_BYTE-1:0]   mem_wren,
    output logic                  mem_enb,
    output logic                  mem_rst,
    output logic                  o_idle,
    output logic [31:0]           o_acc_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_CLR} state_t;

    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_LATENCY - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] clr_rem;
    logic [WCW-1:0]        wait_cnt;

    logic ps_owned, accept, clr_go, clr_last, wait_last;
    logic conf_unused;

    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] sum_res;

    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_idat_d;
    logic [NUM_BYTE-1:0]   mem_wren_d;
    logic                  mem_enb_d;
    logic                  clr_done_d;

    assign ps_owned    = i_conf_ctrl[2];
    assign conf_unused = ^{i_conf_ctrl[31:3], i_conf_ctrl[1:0]};
    assign accept      = (state == S_IDLE) && !ps_owned && !i_clr_start && i_psum_valid;
    assign clr_go      = (state == S_IDLE) && !ps_owned && i_clr_start;
    assign clr_last    = (clr_rem == ADDR_WIDTH'(1));
    assign wait_last   = (wait_cnt == WAIT_LAST);

    assign o_psum_ready = rst_n && (state == S_IDLE) && !ps_owned && !i_clr_start;
    assign o_idle       = (state == S_IDLE);
    assign mem_rst      = 1'b0;

    // Sign-extended add; the extra bit exposes signed overflow for optional clamping
    assign sum_ext = {mem_odat[DATA_WIDTH-1], mem_odat} + {data_q[DATA_WIDTH-1], data_q};

    // Wrap by default, clamp to the signed extreme on overflow when saturating
    always_comb begin
        sum_res = sum_ext[DATA_WIDTH-1:0];
        if (SATURATE != 0 && (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])) begin
            sum_res = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: clear wins over a simultaneous psum request
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr_go) begin
                    if (i_clr_len != '0) state_nxt = S_CLR;
                end else if (accept) begin
                    state_nxt = i_psum_first ? S_WR : S_RD;
                end
            end
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  if (wait_last) state_nxt = S_WR;
            S_WR:    state_nxt = S_IDLE;
            S_CLR:   if (clr_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values the registered BRAM port will present in the next cycle
    always_comb begin
        mem_enb_d  = (state_nxt != S_IDLE);
        mem_wren_d = '0;
        mem_addr_d = mem_addr;
        mem_idat_d = mem_idat;
        clr_done_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_go) begin
                    mem_addr_d = i_clr_base;
                    mem_idat_d = '0;
                    mem_wren_d = (i_clr_len != '0) ? '1 : '0;
                    clr_done_d = (i_clr_len == '0);
                end else if (accept) begin
                    mem_addr_d = i_psum_addr;
                    if (i_psum_first) begin
                        mem_wren_d = '1;
                        mem_idat_d = i_psum_data;
                    end
                end
            end
            S_WAIT: begin
                if (wait_last) begin
                    mem_wren_d = '1;
                    mem_idat_d = sum_res;
                end
            end
            S_CLR: begin
                if (clr_last) begin
                    clr_done_d = 1'b1;
                end else begin
                    mem_addr_d = mem_addr + ADDR_WIDTH'(1);
                    mem_wren_d = '1;
                end
            end
            default: ;
        endcase
    end

    // Registered BRAM port and clear-done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_idat   <= '0;
            mem_wren   <= '0;
            mem_enb    <= 1'b0;
            o_clr_done <= 1'b0;
        end else begin
            mem_addr   <= mem_addr_d;
            mem_idat   <= mem_idat_d;
            mem_wren   <= mem_wren_d;
            mem_enb    <= mem_enb_d;
            o_clr_done <= clr_done_d;
        end
    end

    // Captured request data, clear word countdown, read-latency counter, completed-write count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            clr_rem   <= '0;
            wait_cnt  <= '0;
            o_acc_cnt <= '0;
        end else begin
            if (accept)                        data_q   <= i_psum_data;
            if (clr_go)                        clr_rem  <= i_clr_len;
            else if (state == S_CLR)           clr_rem  <= clr_rem - ADDR_WIDTH'(1);
            if (state == S_RD)                 wait_cnt <= '0;
            else if (state == S_WAIT)          wait_cnt <= wait_cnt + WCW'(1);
            if (state == S_WR)                 o_acc_cnt <= o_acc_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench: two instances (wrap and saturate) share stimulus, each with its own BRAM model.
// Expected BRAM writes are queued when stimulus is driven and compared as writes appear.
module tb_psum_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_conf_ctrl;
    logic        i_psum_valid;
    logic [31:0] i_psum_addr;
    logic [31:0] i_psum_data;
    logic        i_psum_first;
    logic        i_clr_start;
    logic [31:0] i_clr_base;
    logic [31:0] i_clr_len;

    logic        o_psum_ready, o_clr_done, mem_enb, mem_rst, o_idle;
    logic [31:0] mem_addr, mem_idat, mem_odat, o_acc_cnt;
    logic [3:0]  mem_wren;

    logic        o_psum_ready_s, o_clr_done_s, mem_enb_s, mem_rst_s, o_idle_s;
    logic [31:0] mem_addr_s, mem_idat_s, mem_odat_s, o_acc_cnt_s;
    logic [3:0]  mem_wren_s;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];

    logic [31:0] bram0 [logic [31:0]];
    logic [31:0] bram1 [logic [31:0]];
    logic [31:0] rd0_a, rd0_b, rd1_a, rd1_b;

    always #5 clk = ~clk;

    psum_accum_ctrl #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(i_conf_ctrl),
        .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
        .i_psum_addr(i_psum_addr), .i_psum_data(i_psum_data), .i_psum_first(i_psum_first),
        .i_clr_start(i_clr_start), .i_clr_base(i_clr_base), .i_clr_len(i_clr_len),
        .o_clr_done(o_clr_done), .mem_addr(mem_addr), .mem_idat(mem_idat),
        .mem_odat(mem_odat), .mem_wren(mem_wren), .mem_enb(mem_enb), .mem_rst(mem_rst),
        .o_idle(o_idle), .o_acc_cnt(o_acc_cnt)
    );

    psum_accum_ctrl #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(i_conf_ctrl),
        .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready_s),
        .i_psum_addr(i_psum_addr), .i_psum_data(i_psum_data), .i_psum_first(i_psum_first),
        .i_clr_start(i_clr_start), .i_clr_base(i_clr_base), .i_clr_len(i_clr_len),
        .o_clr_done(o_clr_done_s), .mem_addr(mem_addr_s), .mem_idat(mem_idat_s),
        .mem_odat(mem_odat_s), .mem_wren(mem_wren_s), .mem_enb(mem_enb_s), .mem_rst(mem_rst_s),
        .o_idle(o_idle_s), .o_acc_cnt(o_acc_cnt_s)
    );

    // BRAM models: write port, then two-stage registered read (latency 2)
    always @(posedge clk) begin
        if (mem_enb && mem_wren == 4'hF)     bram0[mem_addr]   = mem_idat;
        if (mem_enb_s && mem_wren_s == 4'hF) bram1[mem_addr_s] = mem_idat_s;
    end

    always @(posedge clk) begin
        if (mem_enb && mem_wren == 4'h0)
            rd0_a <= bram0.exists(mem_addr) ? bram0[mem_addr] : 32'h0;
        if (mem_enb_s && mem_wren_s == 4'h0)
            rd1_a <= bram1.exists(mem_addr_s) ? bram1[mem_addr_s] : 32'h0;
        rd0_b <= rd0_a;
        rd1_b <= rd1_a;
    end

    assign mem_odat   = rd0_b;
    assign mem_odat_s = rd1_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every BRAM write must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_enb && mem_wren != 4'h0) begin
            chk("wr_wrap_expected", 64'(exp_q0.size() != 0), 64'd1);
            if (exp_q0.size() != 0) chk("wr_wrap", {mem_addr, mem_idat}, exp_q0.pop_front());
            chk("wr_wrap_bytes", 64'(mem_wren), 64'hF);
        end
        if (rst_n === 1'b1 && mem_enb_s && mem_wren_s != 4'h0) begin
            chk("wr_sat_expected", 64'(exp_q1.size() != 0), 64'd1);
            if (exp_q1.size() != 0) chk("wr_sat", {mem_addr_s, mem_idat_s}, exp_q1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_idle && o_idle_s) break;
        end
        chk("idle_timeout", 64'(o_idle && o_idle_s), 64'd1);
    endtask

    task automatic send_psum(input logic [31:0] a, input logic [31:0] d, input logic f,
                             input logic [31:0] e0, input logic [31:0] e1);
        tick();
        i_psum_valid = 1'b1; i_psum_addr = a; i_psum_data = d; i_psum_first = f;
        exp_q0.push_back({a, e0});
        exp_q1.push_back({a, e1});
        @(negedge clk);
        chk("send_ready", 64'(o_psum_ready), 64'd1);
        tick();
        i_psum_valid = 1'b0; i_psum_first = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [31:0] ea;
        rst_n = 1'b0; i_conf_ctrl = '0; i_psum_valid = 1'b1; i_psum_addr = 32'd5;
        i_psum_data = '0; i_psum_first = 1'b0; i_clr_start = 1'b0; i_clr_base = '0; i_clr_len = '0;

        // Reset with valid asserted
        repeat (2) @(negedge clk);
        chk("rst_ready",   64'(o_psum_ready), 64'd0);
        chk("rst_enb",     64'(mem_enb),      64'd0);
        chk("rst_wren",    64'(mem_wren),     64'd0);
        chk("rst_acc_cnt", 64'(o_acc_cnt),    64'd0);
        chk("rst_idle",    64'(o_idle),       64'd1);
        chk("rst_done",    64'(o_clr_done),   64'd0);
        chk("rst_memrst",  64'(mem_rst),      64'd0);
        tick();
        rst_n = 1'b1; i_psum_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(o_psum_ready), 64'd1);

        // First-pass write: addr 5 <= 10
        tick();
        i_psum_valid = 1'b1; i_psum_addr = 32'd5; i_psum_data = 32'd10; i_psum_first = 1'b1;
        exp_q0.push_back({32'd5, 32'd10});
        exp_q1.push_back({32'd5, 32'd10});
        @(negedge clk);
        chk("first_ready", 64'(o_psum_ready), 64'd1);
        tick();
        i_psum_valid = 1'b0; i_psum_first = 1'b0;
        @(negedge clk);
        chk("first_wren",  64'(mem_wren),     64'hF);
        chk("first_addr",  64'(mem_addr),     64'd5);
        chk("first_idat",  64'(mem_idat),     64'd10);
        chk("first_busy",  64'(o_psum_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("first_ready_back", 64'(o_psum_ready), 64'd1);
        chk("first_acc_cnt",    64'(o_acc_cnt),    64'd1);

        // Accumulate addr 5 += 7: RD at C, WAIT C+1..C+2, WR at C+3
        tick();
        i_psum_valid = 1'b1; i_psum_data = 32'd7;
        exp_q0.push_back({32'd5, 32'd17});
        exp_q1.push_back({32'd5, 32'd17});
        @(negedge clk);
        chk("acc_ready", 64'(o_psum_ready), 64'd1);
        tick();
        i_psum_valid = 1'b0;
        @(negedge clk);
        chk("acc_rd_enb",  64'(mem_enb),  64'd1);
        chk("acc_rd_wren", 64'(mem_wren), 64'd0);
        chk("acc_rd_addr", 64'(mem_addr), 64'd5);
        for (int i = 1; i <= 2; i++) begin
            tick();
            @(negedge clk);
            chk("acc_wait_wren",  64'(mem_wren),     64'd0);
            chk("acc_wait_ready", 64'(o_psum_ready), 64'd0);
        end
        tick();
        @(negedge clk);
        chk("acc_wr_wren", 64'(mem_wren), 64'hF);
        chk("acc_wr_idat", 64'(mem_idat), 64'd17);
        tick();
        @(negedge clk);
        chk("acc_ready_back", 64'(o_psum_ready), 64'd1);
        chk("acc_cnt_2",      64'(o_acc_cnt),    64'd2);

        // Positive and negative overflow: wrap vs saturate
        send_psum(32'd9,  32'h7FFF_FFF0, 1'b1, 32'h7FFF_FFF0, 32'h7FFF_FFF0);
        send_psum(32'd9,  32'h0000_0020, 1'b0, 32'h8000_0010, 32'h7FFF_FFFF);
        send_psum(32'd12, 32'h8000_0005, 1'b1, 32'h8000_0005, 32'h8000_0005);
        send_psum(32'd12, 32'hFFFF_FFF0, 1'b0, 32'h7FFF_FFF5, 32'h8000_0000);
        chk("sat_acc_cnt_wrap", 64'(o_acc_cnt),   64'd6);
        chk("sat_acc_cnt_sat",  64'(o_acc_cnt_s), 64'd6);

        // Clear wins over simultaneous psum, address wraps past 2^32-1
        tick();
        i_clr_start = 1'b1; i_clr_base = 32'hFFFF_FFFE; i_clr_len = 32'd3;
        i_psum_valid = 1'b1; i_psum_addr = 32'd5; i_psum_data = 32'd99; i_psum_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ea = 32'hFFFF_FFFE + 32'(i);
            exp_q0.push_back({ea, 32'h0});
            exp_q1.push_back({ea, 32'h0});
        end
        @(negedge clk);
        chk("clr_ready_blocked", 64'(o_psum_ready), 64'd0);
        tick();
        i_clr_start = 1'b0; i_psum_valid = 1'b0; i_psum_first = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("clr_done_pulse", 64'(o_clr_done), 64'(i == 4));
            if (i <= 3) begin
                ea = 32'hFFFF_FFFE + 32'(i - 1);
                chk("clr_addr", 64'(mem_addr), 64'(ea));
            end
        end
        chk("clr_acc_cnt", 64'(o_acc_cnt), 64'd6);
        chk("clr_idle",    64'(o_idle),    64'd1);

        // Zero-length clear: done next cycle, no BRAM activity
        tick();
        i_clr_start = 1'b1; i_clr_len = 32'd0;
        @(negedge clk);
        chk("clr0_idle", 64'(o_idle), 64'd1);
        tick();
        i_clr_start = 1'b0;
        @(negedge clk);
        chk("clr0_done", 64'(o_clr_done), 64'd1);
        chk("clr0_enb",  64'(mem_enb),    64'd0);
        tick();
        @(negedge clk);
        chk("clr0_done_low", 64'(o_clr_done), 64'd0);

        // PS ownership in IDLE: requests and clear ignored
        tick();
        i_conf_ctrl = 32'h4; i_psum_valid = 1'b1; i_psum_first = 1'b1;
        i_clr_start = 1'b1; i_clr_len = 32'd2; i_clr_base = 32'd0;
        @(negedge clk);
        chk("ps_ready", 64'(o_psum_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ps_enb",  64'(mem_enb),    64'd0);
            chk("ps_done", 64'(o_clr_done), 64'd0);
            chk("ps_idle", 64'(o_idle),     64'd1);
        end
        tick();
        i_conf_ctrl = 32'h0; i_psum_valid = 1'b0; i_psum_first = 1'b0; i_clr_start = 1'b0;

        // PS ownership raised during WAIT: op still completes
        tick();
        i_psum_valid = 1'b1; i_psum_addr = 32'd5; i_psum_data = 32'd3;
        exp_q0.push_back({32'd5, 32'd20});
        exp_q1.push_back({32'd5, 32'd20});
        @(negedge clk);
        chk("midop_ready", 64'(o_psum_ready), 64'd1);
        tick();
        i_psum_valid = 1'b0;
        tick();
        i_conf_ctrl = 32'h4;
        @(negedge clk);
        chk("midop_busy", 64'(o_idle), 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("midop_wren", 64'(mem_wren), 64'hF);
        chk("midop_idat", 64'(mem_idat), 64'd20);
        tick();
        @(negedge clk);
        chk("midop_idle",  64'(o_idle),       64'd1);
        chk("midop_ready_low", 64'(o_psum_ready), 64'd0);
        chk("midop_acc_cnt", 64'(o_acc_cnt),  64'd7);
        tick();
        i_conf_ctrl = 32'h0;
        repeat (2) @(negedge clk);

        chk("sb_wrap_drained", 64'(exp_q0.size()), 64'd0);
        chk("sb_sat_drained",  64'(exp_q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
